dense_head_sequencer: RTL

Sequences the final fully-connected stage of the MNIST classifier. Buffers one flattened feature vector streamed from the pooling stage, launches the Dense engine, and feeds the vector to it word by word. Collects the engine's OUT_COUNT scores, tracks the arg-max, and presents the winning class with a valid/ack handshake. Sits between the pool output stream and the top-level result register; it owns the Dense engine's start and dataIn.

---
 rtl/dense_seq_pkg.sv | 35 +++
 rtl/dense_head_sequencer_if.sv | 35 +++
 rtl/dense_head_sequencer_argmax_tracker.sv | 57 +++++
 rtl/dense_head_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dense_seq_pkg.sv
// Shared sizes, state encoding and compare helper for the Dense head
// sequencer slice.
package dense_seq_pkg;

    localparam int IN_COUNT  = 169;
    localparam int OUT_COUNT = 10;
    localparam int DATA_SIZE = 16;
    localparam int TIMEOUT   = 4096;

    localparam int CNT_W  = $clog2(IN_COUNT);
    localparam int IDX_W  = $clog2(OUT_COUNT);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam int OCNT_W = $clog2(OUT_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_COUNT - 1);
    localparam logic [OCNT_W-1:0] OUT_FULL = OCNT_W'(OUT_COUNT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef logic [DATA_SIZE-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_KICK    = 3'd2,
        ST_FEED    = 3'd3,
        ST_COLLECT = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    function automatic logic sgt(input word_t a, input word_t b);
        return $signed(a) > $signed(b);
    endfunction

endpackage

// File: rtl/dense_head_sequencer_if.sv
// Pool stream, Dense engine and result handshake bundle of the
// sequencer; slave is the sequencer's view, master the environment's.
interface dense_head_sequencer_if;
    import dense_seq_pkg::*;

    logic             inValid;
    word_t            inData;
    logic             inReady;
    logic             denseStart;
    word_t            denseDataIn;
    logic             denseBusy;
    logic             denseValid;
    word_t            denseDataOut;
    logic             classValid;
    logic [IDX_W-1:0] classIdx;
    word_t            classScore;
    logic             classAck;
    logic             busy;
    logic             err;

    modport slave (
        input  inValid, inData, denseBusy, denseValid,
        input  denseDataOut, classAck,
        output inReady, denseStart, denseDataIn,
        output classValid, classIdx, classScore, busy, err
    );

    modport master (
        output inValid, inData, denseBusy, denseValid,
        output denseDataOut, classAck,
        input  inReady, denseStart, denseDataIn,
        input  classValid, classIdx, classScore, busy, err
    );

endinterface

// File: rtl/dense_head_sequencer_argmax_tracker.sv
// Running signed arg-max over a stream of scores; the first word seeds
// the maximum and ties keep the earliest index.
module argmax_tracker
    import dense_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  word_t            data,
    output word_t            max,
    output logic [IDX_W-1:0] idx
);

    logic             have_q, have_d;
    word_t            max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        have_d = have_q;
        max_d  = max_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        if (clear) begin
            have_d = 1'b0;
            max_d  = '0;
            idx_d  = '0;
            cnt_d  = '0;
        end else if (valid) begin
            cnt_d = cnt_q + 1'b1;
            if (!have_q || sgt(data, max_q)) begin
                have_d = 1'b1;
                max_d  = data;
                idx_d  = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            have_q <= 1'b0;
            max_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            have_q <= have_d;
            max_q  <= max_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

    assign max = max_q;
    assign idx = idx_q;

endmodule

// File: rtl/dense_head_sequencer.sv
// Buffers one flattened feature vector, drives the Dense engine with it
// and reports the arg-max class of the returned scores.
module dense_head_sequencer
    import dense_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    dense_head_sequencer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [TMO_W-1:0]  idle_q, idle_d;
    word_t             feat_q [IN_COUNT];

    logic             accept;
    logic             start;
    logic             collecting;
    logic             count;
    logic             trk_clear;
    word_t            trk_max;
    logic [IDX_W-1:0] trk_idx;

    assign accept     = (state_q == ST_LOAD) && bus.inValid;
    // Start is gated by the engine's live busy so it fires in the first free cycle.
    assign start      = (state_q == ST_KICK) && !bus.denseBusy;
    assign collecting = (state_q == ST_FEED) || (state_q == ST_COLLECT);
    assign count      = collecting && bus.denseValid
                        && (out_cnt_q != OUT_FULL);
    assign trk_clear  = !collecting && (state_q != ST_DONE);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        idle_d    = '0;

        if (count) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == CNT_LAST) begin
                        wr_cnt_d = '0;
                        state_d  = ST_KICK;
                    end
                end
            end
            ST_KICK: begin
                if (start) begin
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_FEED;
                end
            end
            ST_FEED: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == CNT_LAST) begin
                    rd_cnt_d = '0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (out_cnt_d == OUT_FULL) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.classAck) begin
                    wr_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_ERR: begin
                wr_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // Idle watchdog spans FEED and COLLECT; a stall overrides any move.
        if (collecting) begin
            idle_d = bus.denseValid ? '0 : idle_q + 1'b1;
            if (!bus.denseValid && (idle_q == TMO_LAST)) begin
                state_d = ST_ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            idle_q    <= idle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            feat_q[wr_cnt_q] <= bus.inData;
        end
    end

    argmax_tracker u_argmax (
        .clk   (clk),
        .rst   (rst),
        .clear (trk_clear),
        .valid (count),
        .data  (bus.denseDataOut),
        .max   (trk_max),
        .idx   (trk_idx)
    );

    assign bus.inReady     = (state_q == ST_LOAD);
    assign bus.denseStart  = start;
    assign bus.denseDataIn = (state_q == ST_FEED) ? feat_q[rd_cnt_q] : '0;
    assign bus.classValid  = (state_q == ST_DONE);
    assign bus.classIdx    = (state_q == ST_DONE) ? trk_idx : '0;
    assign bus.classScore  = (state_q == ST_DONE) ? trk_max : '0;
    assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_LOAD);
    assign bus.err         = (state_q == ST_ERR);

endmodule
